// File: rtl/cb_resp_pkg.sv
// Shared types, default parameters and payload transform
// for the cb_handshake_responder slice.
package cb_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    DRAIN
  } cb_resp_state_e;

  localparam int DW_D      = 8;
  localparam int LATENCY_D = 3;
  localparam int CNT_W_D   = 8;
  localparam int TIMEOUT_D = 16;

  localparam int XW = 64;

  // Response payload is the request payload plus one.
  // Callers truncate to their own width.
  function automatic logic [XW-1:0] rsp_xform(
    input logic [XW-1:0] data
  );
    return data + 64'd1;
  endfunction

endpackage

// File: rtl/cb_resp_delay_cnt.sv
// Loadable down-counter with synchronous active-low clear.
// Saturates at zero; zero flag is decoded from the register.
module cb_resp_delay_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] r_cnt;

  // Load has priority over decrement; stop at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= value;
    end else if (dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/cb_handshake_responder.sv
// 4-phase req/ack responder with fixed latency and txn counter.
// Optional ACK timeout with DRAIN state under `RSP_TIMEOUT_EN.
module cb_handshake_responder
  import cb_resp_pkg::*;
#(
  parameter int DW      = DW_D,
  parameter int LATENCY = LATENCY_D,
`ifdef RSP_TIMEOUT_EN
  parameter int TIMEOUT = TIMEOUT_D,
`endif
  parameter int CNT_W   = CNT_W_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [DW-1:0]    req_data,
  output logic             ack,
  output logic [DW-1:0]    rsp_data,
  output logic             busy,
  output logic [CNT_W-1:0] txn_cnt,
  output logic             err
);

  localparam int LW = 4;

  cb_resp_state_e r_state;
  logic             r_ack;
  logic             r_busy;
  logic [DW-1:0]    r_data;
  logic [DW-1:0]    r_rsp;
  logic [CNT_W-1:0] r_cnt;

  logic w_lat_load;
  logic w_lat_dec;
  logic w_lat_zero;

  assign w_lat_load = (r_state == IDLE) && req;
  assign w_lat_dec  = (r_state == WAIT);

  cb_resp_delay_cnt #(
    .W (LW)
  ) u_lat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_lat_load),
    .value (LW'(LATENCY - 1)),
    .dec   (w_lat_dec),
    .zero  (w_lat_zero)
  );

`ifdef RSP_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic r_err;
  logic w_to_load;
  logic w_to_dec;
  logic w_to_zero;

  assign w_to_load = (r_state == WAIT) && req && w_lat_zero;
  assign w_to_dec  = (r_state == ACK);

  cb_resp_delay_cnt #(
    .W (TW)
  ) u_to_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_to_load),
    .value (TW'(TIMEOUT - 1)),
    .dec   (w_to_dec),
    .zero  (w_to_zero)
  );

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  // Handshake FSM with registered ack, busy, payload and count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_data  <= '0;
      r_rsp   <= '0;
      r_cnt   <= '0;
`ifdef RSP_TIMEOUT_EN
      r_err   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req) begin
            r_data  <= req_data;
            r_state <= WAIT;
            r_busy  <= 1'b1;
          end
        end
        WAIT: begin
          if (!req) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_lat_zero) begin
            r_state <= ACK;
            r_ack   <= 1'b1;
            r_rsp   <= DW'(rsp_xform(XW'(r_data)));
          end
        end
        ACK: begin
          if (!req) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= r_cnt + CNT_W'(1);
          end
`ifdef RSP_TIMEOUT_EN
          else if (w_to_zero) begin
            r_state <= DRAIN;
            r_ack   <= 1'b0;
            r_err   <= 1'b1;
          end
`endif
        end
        DRAIN: begin
`ifdef RSP_TIMEOUT_EN
          if (!req) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
`else
          r_state <= IDLE;
          r_busy  <= 1'b0;
`endif
        end
        default: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ack      = r_ack;
  assign rsp_data = r_rsp;
  assign busy     = r_busy;
  assign txn_cnt  = r_cnt;

endmodule

// File: tb/tb_cb_handshake_responder.sv
// Randomized bench for cb_handshake_responder against a
// transaction-level model; timeout checks under RSP_TIMEOUT_EN.
module tb_cb_handshake_responder;

  localparam int LAT = 3;
  localparam int TO  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       ack;
  logic [7:0] rsp_data;
  logic       busy;
  logic [7:0] txn_cnt;
  logic       err;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] exp_cnt = 8'h00;
  logic [7:0] exp_rsp = 8'h00;
  logic       exp_err = 1'b0;

  cb_handshake_responder u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .rsp_data (rsp_data),
    .busy     (busy),
    .txn_cnt  (txn_cnt),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst();
    chk("rst_ack",  32'(ack),      0);
    chk("rst_busy", 32'(busy),     0);
    chk("rst_cnt",  32'(txn_cnt),  0);
    chk("rst_rsp",  32'(rsp_data), 0);
    chk("rst_err",  32'(err),      0);
  endtask

  // One full transaction: ack must rise exactly LAT edges
  // after req is first sampled, fall one edge after req drops.
  task automatic do_txn(
    input logic [7:0] d,
    input int         hold,
    input int         gap
  );
    req      = 1'b1;
    req_data = d;
    step();
    chk("busy_wait", 32'(busy), 1);
    chk("ack_early", 32'(ack),  0);
    req_data = 8'($urandom);
    for (int i = 1; i < LAT; i++) begin
      step();
      chk("ack_early", 32'(ack),      0);
      chk("rsp_prev",  32'(rsp_data), 32'(exp_rsp));
    end
    step();
    exp_rsp = d + 8'd1;
    chk("ack_rise", 32'(ack),      1);
    chk("rsp",      32'(rsp_data), 32'(exp_rsp));
    chk("cnt_mid",  32'(txn_cnt),  32'(exp_cnt));
    for (int i = 0; i < hold; i++) begin
      step();
      chk("ack_hold", 32'(ack), 1);
    end
    req = 1'b0;
    step();
    exp_cnt = exp_cnt + 8'd1;
    chk("ack_fall",  32'(ack),      0);
    chk("cnt",       32'(txn_cnt),  32'(exp_cnt));
    chk("busy_idle", 32'(busy),     0);
    chk("rsp_keep",  32'(rsp_data), 32'(exp_rsp));
    chk("err",       32'(err),      32'(exp_err));
    for (int i = 0; i < gap; i++) begin
      step();
      chk("ack_gap", 32'(ack), 0);
    end
  endtask

  // req high for k sampled edges (1..LAT) then withdrawn.
  task automatic do_abort(input int k);
    req      = 1'b1;
    req_data = 8'($urandom);
    step();
    chk("ab_busy", 32'(busy), 1);
    for (int i = 1; i < k; i++) begin
      step();
      chk("ab_ack", 32'(ack), 0);
    end
    req = 1'b0;
    step();
    chk("ab_ack",  32'(ack),  0);
    chk("ab_busy", 32'(busy), 0);
    step();
    chk("ab_ack2", 32'(ack),      0);
    chk("ab_cnt",  32'(txn_cnt),  32'(exp_cnt));
    chk("ab_rsp",  32'(rsp_data), 32'(exp_rsp));
    chk("ab_err",  32'(err),      32'(exp_err));
  endtask

  initial begin
    logic [7:0] c0;
    int         done;

    rst_n = 1'b0;
    step();
    step();
    chk_rst();
    rst_n = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 0);

    do_txn(8'h41, 3, 1);
    chk("basic_cnt", 32'(txn_cnt), 1);

    do_txn(8'hFF, 0, 2);
    chk("wrap_rsp", 32'(rsp_data), 0);

    do_abort(1);
    do_abort(LAT);

    do_txn(8'($urandom), 0, 0);
    do_txn(8'($urandom), 1, 0);
    do_txn(8'($urandom), 2, 2);

    req      = 1'b1;
    req_data = 8'h5A;
    repeat (LAT + 1) step();
    chk("mid_ack", 32'(ack), 1);
    rst_n = 1'b0;
    req   = 1'b0;
    step();
    chk_rst();
    exp_cnt = 8'h00;
    exp_rsp = 8'h00;
    rst_n   = 1'b1;
    do_txn(8'h10, 1, 1);
    chk("post_rst_cnt", 32'(txn_cnt), 1);

    c0   = exp_cnt;
    done = 0;
    while (done < 256) begin
      if ($urandom_range(0, 7) == 0) begin
        do_abort(int'($urandom_range(1, LAT)));
      end else begin
        do_txn(8'($urandom), int'($urandom_range(0, 5)),
               int'($urandom_range(0, 3)));
        done++;
      end
    end
    chk("cnt_wrap", 32'(txn_cnt), 32'(c0));

`ifdef RSP_TIMEOUT_EN
    req      = 1'b1;
    req_data = 8'h33;
    repeat (LAT + 1) step();
    chk("to_ack", 32'(ack), 1);
    for (int i = 1; i < TO; i++) begin
      step();
      chk("to_hold", 32'(ack), 1);
    end
    step();
    exp_rsp = 8'h34;
    chk("to_ack0", 32'(ack),     0);
    chk("to_err",  32'(err),     1);
    chk("to_busy", 32'(busy),    1);
    chk("to_cnt",  32'(txn_cnt), 32'(exp_cnt));
    step();
    chk("drain_busy", 32'(busy), 1);
    req = 1'b0;
    step();
    chk("drain_exit", 32'(busy), 0);
    chk("err_stick",  32'(err),  1);
    exp_err = 1'b1;
    do_txn(8'h77, 2, 1);
    rst_n = 1'b0;
    step();
    chk_rst();
    rst_n   = 1'b1;
    exp_err = 1'b0;
    exp_cnt = 8'h00;
    exp_rsp = 8'h00;
    step();
`else
    chk("err_tied", 32'(err), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
